// File: rtl/start_sequencer_pkg.sv
// Shared types and default parameters for the start sequencer that feeds the up/down sweep counter.
package start_sequencer_pkg;

    localparam int DEF_PEND_W         = 4;
    localparam int DEF_MAX_PEND       = 15;
    localparam int DEF_GAP_CYCLES     = 2;
    localparam int DEF_TIMEOUT_CYCLES = 8;

    typedef enum logic [2:0] {
        s_IDLE      = 3'd0,
        s_ISSUE     = 3'd1,
        s_WAIT_BUSY = 3'd2,
        s_WAIT_DONE = 3'd3,
        s_GAP       = 3'd4
    } seq_state_t;

    // The timer has to hold GAP_CYCLES-1 and TIMEOUT_CYCLES-1; it is never narrower than one bit.
    function automatic int timer_width(input int gap_cycles, input int timeout_cycles);
        int span;
        span = (gap_cycles > timeout_cycles) ? gap_cycles : timeout_cycles;
        return (span < 2) ? 1 : $clog2(span);
    endfunction

endpackage

// File: rtl/start_sequencer_cycle_timer.sv
// Loadable up/down cycle timer with a zero flag, shared by the gap and start-timeout paths.
module start_sequencer_cycle_timer #(
    parameter int W = 3
) (
    input  logic         in_clock,
    input  logic         in_reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         count_up,
    input  logic         count_down,
    output logic [W-1:0] value,
    output logic         zero
);

    // NOTE: clocked state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (count_up) begin
            value <= value + 1'b1;
        end else if (count_down) begin
            value <= value - 1'b1;
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/start_sequencer.sv
// Queues start requests and issues them to the sweep counter one sweep at a time with a gap between.
// Optional feature: define START_TIMEOUT_EN to abandon a start whose ready never falls.
module start_sequencer
    import start_sequencer_pkg::*;
#(
    parameter int PEND_W         = DEF_PEND_W,
    parameter int MAX_PEND       = DEF_MAX_PEND,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              in_clock,
    input  logic              in_reset,
    input  logic              in_req,
    input  logic              in_count_ready,
    output logic              out_start,
    output logic [PEND_W-1:0] out_pending,
    output logic              out_busy,
    output logic              out_overflow,
    output logic              out_timeout
);

    localparam int                TIMER_W    = timer_width(GAP_CYCLES, TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? TIMER_W'(GAP_CYCLES - 1) : '0;
    localparam logic [PEND_W-1:0]  PEND_LIMIT = PEND_W'(MAX_PEND);

    seq_state_t        state;
    logic [PEND_W-1:0] pending;
    logic              issue;
    logic              req_accept;

    logic               timer_load;
    logic [TIMER_W-1:0] timer_load_value;
    logic               timer_up;
    logic               timer_down;
    logic [TIMER_W-1:0] timer_value;
    logic               timer_zero;

`ifdef START_TIMEOUT_EN
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    logic timeout_q;
    logic timeout_hit;

    assign timeout_hit = (timer_value == TIMEOUT_LAST);
    assign out_timeout = timeout_q;
`else
    logic unused_timer_value;

    assign unused_timer_value = ^timer_value;
    assign out_timeout        = 1'b0;
`endif

    // A full queue still accepts a request on the same edge that an issue frees a slot.
    always_comb begin
        issue      = (state == s_IDLE) && (pending != '0) && in_count_ready;
        req_accept = in_req && ((pending != PEND_LIMIT) || issue);
    end

    // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
    always_comb begin
        timer_load       = 1'b0;
        timer_load_value = '0;
        timer_up         = 1'b0;
        timer_down       = 1'b0;
        unique case (state)
            s_ISSUE: begin
                timer_load = 1'b1;
            end
            s_WAIT_BUSY: begin
`ifdef START_TIMEOUT_EN
                timer_up = in_count_ready && !timeout_hit;
`endif
            end
            s_WAIT_DONE: begin
                timer_load       = in_count_ready && (GAP_CYCLES > 0);
                timer_load_value = GAP_LOAD;
            end
            s_GAP: begin
                timer_down = !timer_zero;
            end
            default: begin
            end
        endcase
    end

    start_sequencer_cycle_timer #(
        .W (TIMER_W)
    ) u_timer (
        .in_clock   (in_clock),
        .in_reset   (in_reset),
        .load       (timer_load),
        .load_value (timer_load_value),
        .count_up   (timer_up),
        .count_down (timer_down),
        .value      (timer_value),
        .zero       (timer_zero)
    );

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state        <= s_IDLE;
            pending      <= '0;
            out_start    <= 1'b0;
            out_overflow <= 1'b0;
`ifdef START_TIMEOUT_EN
            timeout_q    <= 1'b0;
`endif
        end else begin
            if (req_accept && !issue) begin
                pending <= pending + 1'b1;
            end else if (issue && !req_accept) begin
                pending <= pending - 1'b1;
            end

            if (in_req && !req_accept) begin
                out_overflow <= 1'b1;
            end

            out_start <= 1'b0;
            unique case (state)
                s_IDLE: begin
                    if (issue) begin
                        state     <= s_ISSUE;
                        out_start <= 1'b1;
                    end
                end
                s_ISSUE: begin
                    state <= s_WAIT_BUSY;
                end
                s_WAIT_BUSY: begin
                    if (!in_count_ready) begin
                        state <= s_WAIT_DONE;
                    end
`ifdef START_TIMEOUT_EN
                    // The issued request is consumed; it is not put back in the queue.
                    else if (timeout_hit) begin
                        timeout_q <= 1'b1;
                        state     <= s_IDLE;
                    end
`endif
                end
                s_WAIT_DONE: begin
                    if (in_count_ready) begin
                        state <= (GAP_CYCLES == 0) ? s_IDLE : s_GAP;
                    end
                end
                s_GAP: begin
                    if (timer_zero) begin
                        state <= s_IDLE;
                    end
                end
                default: begin
                    state <= s_IDLE;
                end
            endcase
        end
    end

    assign out_pending = pending;
    assign out_busy    = (state != s_IDLE);

endmodule

// File: tb/tb_start_sequencer.sv
// Directed self-checking bench for start_sequencer; the sweep counter's ready line is scripted per cycle.
module tb_start_sequencer;

    logic       in_clock = 1'b0;
    logic       in_reset = 1'b1;
    logic       in_req = 1'b0;
    logic       in_count_ready = 1'b1;
    logic       out_start;
    logic [3:0] out_pending;
    logic       out_busy;
    logic       out_overflow;
    logic       out_timeout;

    int tests_run = 0;
    int tests_failed = 0;

    start_sequencer #(
        .PEND_W         (4),
        .MAX_PEND       (15),
        .GAP_CYCLES     (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .in_clock       (in_clock),
        .in_reset       (in_reset),
        .in_req         (in_req),
        .in_count_ready (in_count_ready),
        .out_start      (out_start),
        .out_pending    (out_pending),
        .out_busy       (out_busy),
        .out_overflow   (out_overflow),
        .out_timeout    (out_timeout)
    );

    always #5 in_clock = ~in_clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Observed outputs packed as {start, busy, overflow, timeout, pending}.
    function automatic logic [7:0] snap();
        return {out_start, out_busy, out_overflow, out_timeout, out_pending};
    endfunction

    function automatic logic [7:0] want(input logic st, input logic bz, input logic ov,
                                        input logic to, input logic [3:0] pd);
        return {st, bz, ov, to, pd};
    endfunction

    task automatic tick();
        @(posedge in_clock);
        #1;
    endtask

    task automatic do_reset();
        in_reset = 1'b1;
        in_req   = 1'b0;
        tick();
        in_reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        in_reset = 1'b1;
        in_req = 1'b1;
        in_count_ready = 1'b1;
        tick();
        exp = want(0, 0, 0, 0, 4'd0);
        tests_run++;
        if (snap() !== exp) begin
            tests_failed++;
            $display("FAIL reset_state: got %h want %h", snap(), exp);
        end
        in_reset = 1'b0;
        in_req = 1'b0;
        tick();
        tests_run++;
        if (snap() !== exp) begin
            tests_failed++;
            $display("FAIL reset_drops_req: got %h want %h", snap(), exp);
        end
    endtask

    task automatic test_single();
        logic [7:0] exp;
        do_reset();
        in_count_ready = 1'b1;
        in_req = 1'b1;
        tick();
        in_req = 1'b0;
        exp = want(0, 0, 0, 0, 4'd1);
        tests_run++;
        if (snap() !== exp) begin
            tests_failed++;
            $display("FAIL single_queued: got %h want %h", snap(), exp);
        end
        tick();
        exp = want(1, 1, 0, 0, 4'd0);
        tests_run++;
        if (snap() !== exp) begin
            tests_failed++;
            $display("FAIL single_start: got %h want %h", snap(), exp);
        end
        tick();
        exp = want(0, 1, 0, 0, 4'd0);
        tests_run++;
        if (snap() !== exp) begin
            tests_failed++;
            $display("FAIL single_start_one_cycle: got %h want %h", snap(), exp);
        end
        in_count_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        tests_run++;
        if (snap() !== exp) begin
            tests_failed++;
            $display("FAIL single_sweeping: got %h want %h", snap(), exp);
        end
        in_count_ready = 1'b1;
        tick();
        tick();
        tests_run++;
        if (snap() !== exp) begin
            tests_failed++;
            $display("FAIL single_gap_busy: got %h want %h", snap(), exp);
        end
        tick();
        exp = want(0, 0, 0, 0, 4'd0);
        tests_run++;
        if (snap() !== exp) begin
            tests_failed++;
            $display("FAIL single_idle_after_gap: got %h want %h", snap(), exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        int         early_starts;
        do_reset();
        in_count_ready = 1'b1;
        in_req = 1'b1;
        tick();
        tick();
        in_req = 1'b0;
        exp = want(1, 1, 0, 0, 4'd1);
        tests_run++;
        if (snap() !== exp) begin
            tests_failed++;
            $display("FAIL b2b_first_start: got %h want %h", snap(), exp);
        end
        early_starts = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (out_start) early_starts++;
        end
        in_count_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (out_start) early_starts++;
        end
        in_count_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (out_start) early_starts++;
        end
        tests_run++;
        if (early_starts !== 0) begin
            tests_failed++;
            $display("FAIL b2b_no_early_start: got %0d starts want 0", early_starts);
        end
        exp = want(0, 0, 0, 0, 4'd1);
        tests_run++;
        if (snap() !== exp) begin
            tests_failed++;
            $display("FAIL b2b_idle_before_second: got %h want %h", snap(), exp);
        end
        tick();
        exp = want(1, 1, 0, 0, 4'd0);
        tests_run++;
        if (snap() !== exp) begin
            tests_failed++;
            $display("FAIL b2b_second_start: got %h want %h", snap(), exp);
        end
    endtask

    // Waits for one start with ready high, then scripts a short sweep and the gap back to idle.
    task automatic run_sweep(input string name);
        bit got;
        got = 1'b0;
        in_count_ready = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (out_start) got = 1'b1;
        end
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("FAIL %s: no start within 20 cycles, want start", name);
        end
        tick();
        in_count_ready = 1'b0;
        tick();
        tick();
        in_count_ready = 1'b1;
        tick();
        tick();
        tick();
    endtask

    task automatic test_overflow();
        logic [7:0] exp;
        do_reset();
        in_count_ready = 1'b0;
        in_req = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        exp = want(0, 0, 0, 0, 4'd15);
        tests_run++;
        if (snap() !== exp) begin
            tests_failed++;
            $display("FAIL ovf_at_limit: got %h want %h", snap(), exp);
        end
        tick();
        tick();
        in_req = 1'b0;
        exp = want(0, 0, 1, 0, 4'd15);
        tests_run++;
        if (snap() !== exp) begin
            tests_failed++;
            $display("FAIL ovf_saturated: got %h want %h", snap(), exp);
        end
        for (int i = 0; i < 15; i++) run_sweep("ovf_drain_start");
        exp = want(0, 0, 1, 0, 4'd0);
        tests_run++;
        if (snap() !== exp) begin
            tests_failed++;
            $display("FAIL ovf_sticky_after_drain: got %h want %h", snap(), exp);
        end
    endtask

    task automatic test_same_edge();
        logic [7:0] exp;
        do_reset();
        in_count_ready = 1'b0;
        in_req = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        in_count_ready = 1'b1;
        tick();
        in_req = 1'b0;
        exp = want(1, 1, 0, 0, 4'd3);
        tests_run++;
        if (snap() !== exp) begin
            tests_failed++;
            $display("FAIL same_edge_pend3: got %h want %h", snap(), exp);
        end
        do_reset();
        in_count_ready = 1'b0;
        in_req = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        in_count_ready = 1'b1;
        tick();
        in_req = 1'b0;
        exp = want(1, 1, 0, 0, 4'd15);
        tests_run++;
        if (snap() !== exp) begin
            tests_failed++;
            $display("FAIL same_edge_full_no_ovf: got %h want %h", snap(), exp);
        end
    endtask

    task automatic test_reset_mid_sweep();
        logic [7:0] exp;
        do_reset();
        in_count_ready = 1'b0;
        in_req = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        in_req = 1'b0;
        in_count_ready = 1'b1;
        tick();
        tick();
        in_count_ready = 1'b0;
        tick();
        exp = want(0, 1, 0, 0, 4'd5);
        tests_run++;
        if (snap() !== exp) begin
            tests_failed++;
            $display("FAIL mid_wait_done: got %h want %h", snap(), exp);
        end
        in_reset = 1'b1;
        in_count_ready = 1'b1;
        tick();
        in_reset = 1'b0;
        exp = want(0, 0, 0, 0, 4'd0);
        tests_run++;
        if (snap() !== exp) begin
            tests_failed++;
            $display("FAIL mid_reset_clears: got %h want %h", snap(), exp);
        end
        tick();
        tick();
        tests_run++;
        if (snap() !== exp) begin
            tests_failed++;
            $display("FAIL mid_reset_no_start: got %h want %h", snap(), exp);
        end
    endtask

`ifdef START_TIMEOUT_EN
    task automatic test_timeout();
        logic [7:0] exp;
        do_reset();
        in_count_ready = 1'b1;
        in_req = 1'b1;
        tick();
        in_req = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 7; i++) tick();
        exp = want(0, 1, 0, 0, 4'd0);
        tests_run++;
        if (snap() !== exp) begin
            tests_failed++;
            $display("FAIL timeout_not_yet: got %h want %h", snap(), exp);
        end
        tick();
        exp = want(0, 0, 0, 1, 4'd0);
        tests_run++;
        if (snap() !== exp) begin
            tests_failed++;
            $display("FAIL timeout_fired: got %h want %h", snap(), exp);
        end
        tick();
        tests_run++;
        if (snap() !== exp) begin
            tests_failed++;
            $display("FAIL timeout_sticky: got %h want %h", snap(), exp);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_same_edge();
        test_reset_mid_sweep();
`ifdef START_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
